// File: rtl/router_nport.sv
// Single-input packet router: header/payload/parity packets are steered into one of
// N output FIFOs, with parity checking, oversize/bad-destination drop and idle-port timeout flush.
module router_nport #(
  parameter int N       = 3,
  parameter int W       = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pkt_valid,
  input  logic [W-1:0]     data_in,
  input  logic [N-1:0]     read_enb,
  output logic             busy,
  output logic             error,
  output logic             drop,
  output logic [N-1:0]     valid_out,
  output logic [N*W-1:0]   data_out
);

  localparam int AW = (N <= 2) ? 1 : $clog2(N);
  localparam int LW = W - AW;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, PARITY, DROP} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    hdr_r;
  logic [AW-1:0]   dest_r;
  logic [LW-1:0]   cnt_r;
  logic [W-1:0]    acc_r;
  logic            dead_r;

  logic [W-1:0]    mem    [N][DEPTH];
  logic [PW-1:0]   wr_ptr [N];
  logic [PW-1:0]   rd_ptr [N];
  logic [OW-1:0]   occ    [N];
  logic [7:0]      tcnt   [N];
  logic [W-1:0]    dout   [N];

  logic            accept;
  logic [AW-1:0]   in_dest;
  logic [LW-1:0]   in_len;
  logic [31:0]     need_in, need_held, free_in, free_held;
  logic            flush_in, flush_dest;
  logic [N-1:0]    flush, wr_hit, rd_hit;
  logic            wr_en, hdr_wr, hdr_dead, drop_entry, err_set;
  logic [AW-1:0]   wr_dest;
  logic [W-1:0]    wr_data;

  assign busy      = (state == WAIT);
  assign accept    = pkt_valid & ~busy;
  assign in_dest   = data_in[AW-1:0];
  assign in_len    = data_in[W-1:AW];
  assign need_in   = 32'(in_len) + 32'd2;
  assign need_held = 32'(cnt_r) + 32'd2;

  always_comb begin
    free_in    = '0;
    free_held  = '0;
    flush_in   = 1'b0;
    flush_dest = 1'b0;
    flush      = '0;
    valid_out  = '0;
    rd_hit     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      valid_out[i] = (occ[i] != '0);
      rd_hit[i]    = read_enb[i] & valid_out[i];
      flush[i]     = valid_out[i] & ~read_enb[i] & (tcnt[i] == 8'(TIMEOUT - 1));
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(in_dest) == i) begin
        free_in  = 32'(DEPTH) - 32'(occ[i]);
        flush_in = flush[i];
      end
      if (32'(dest_r) == i) begin
        free_held  = 32'(DEPTH) - 32'(occ[i]);
        flush_dest = flush[i];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    wr_en      = 1'b0;
    wr_dest    = dest_r;
    wr_data    = data_in;
    hdr_wr     = 1'b0;
    hdr_dead   = 1'b0;
    drop_entry = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (32'(in_dest) >= 32'(N) || need_in > 32'(DEPTH)) begin
          state_nx   = DROP;
          drop_entry = 1'b1;
        end else if (free_in >= need_in) begin
          wr_en    = 1'b1;
          hdr_wr   = 1'b1;
          hdr_dead = flush_in;
          wr_dest  = in_dest;
          state_nx = (in_len == '0) ? PARITY : LOAD;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: if (free_held >= need_held) begin
        wr_en    = 1'b1;
        hdr_wr   = 1'b1;
        hdr_dead = flush_dest;
        wr_data  = hdr_r;
        state_nx = (cnt_r == '0) ? PARITY : LOAD;
      end
      LOAD: if (accept) begin
        wr_en = ~dead_r;
        if (cnt_r == LW'(1)) state_nx = PARITY;
      end
      PARITY: if (accept) begin
        wr_en    = ~dead_r;
        err_set  = (data_in != acc_r) & ~dead_r & ~flush_dest;
        state_nx = IDLE;
      end
      DROP: if (accept && cnt_r == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < N; i++)
      wr_hit[i] = wr_en & (32'(wr_dest) == i);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      hdr_r  <= '0;
      dest_r <= '0;
      cnt_r  <= '0;
      acc_r  <= '0;
      dead_r <= 1'b0;
      error  <= 1'b0;
      drop   <= 1'b0;
    end else begin
      state <= state_nx;
      error <= err_set;
      drop  <= drop_entry | (|flush);
      if (state == IDLE && accept) begin
        hdr_r  <= data_in;
        dest_r <= in_dest;
        cnt_r  <= in_len;
        acc_r  <= data_in;
      end else if (state == LOAD && accept) begin
        acc_r <= acc_r ^ data_in;
        cnt_r <= cnt_r - 1'b1;
      end else if (state == DROP && accept && cnt_r != '0) begin
        cnt_r <= cnt_r - 1'b1;
      end
      // A flush of the active destination orphans the rest of the packet.
      if (hdr_wr)
        dead_r <= hdr_dead;
      else if ((state == LOAD || state == PARITY) && flush_dest)
        dead_r <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
        tcnt[i]   <= '0;
        dout[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (flush[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          occ[i]    <= '0;
        end else begin
          if (wr_hit[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (rd_hit[i]) begin
            rd_ptr[i] <= rd_ptr[i] + 1'b1;
            dout[i]   <= mem[i][rd_ptr[i]];
          end
          occ[i] <= occ[i] + OW'(wr_hit[i]) - OW'(rd_hit[i]);
        end
        if (!valid_out[i] || read_enb[i] || flush[i])
          tcnt[i] <= '0;
        else
          tcnt[i] <= tcnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N; i++)
      if (wr_hit[i] && !flush[i]) mem[i][wr_ptr[i]] <= wr_data;
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign data_out[g*W +: W] = dout[g];
  end

endmodule

// File: tb/tb_router_nport.sv
// Directed bench for router_nport at default parameters (N=3, W=8, DEPTH=16, TIMEOUT=30).
module tb_router_nport;
  localparam int N = 3;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           pkt_valid = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic [N-1:0]   read_enb = '0;
  logic           busy, error, drop;
  logic [N-1:0]   valid_out;
  logic [N*W-1:0] data_out;

  int nerr = 0;
  int nchecks = 0;

  always #5 clock = ~clock;

  router_nport #(.N(N), .W(W), .DEPTH(16), .TIMEOUT(30)) dut (
    .clock(clock), .reset_n(reset_n), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb(read_enb), .busy(busy), .error(error), .drop(drop),
    .valid_out(valid_out), .data_out(data_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pkt_valid = 1'b1;
    data_in   = b;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic read_port(input int p, output logic [7:0] d);
    read_enb[p] = 1'b1;
    tick();
    d = data_out[p*W +: W];
    read_enb[p] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    nchecks++;
    if ({busy, error, drop} !== 3'b000) begin
      nerr++; $display("FAIL reset_flags got=%b want=000", {busy, error, drop});
    end
    nchecks++;
    if (valid_out !== 3'b000 || data_out !== '0) begin
      nerr++; $display("FAIL reset_outputs valid=%b data=%h want 0", valid_out, data_out);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic [7:0] d;
    foreach (pkt[i]) send_byte(pkt[i]);
    nchecks++;
    if (error !== 1'b0) begin nerr++; $display("FAIL basic_error got=%b want=0", error); end
    nchecks++;
    if (valid_out !== 3'b010) begin nerr++; $display("FAIL basic_valid got=%b want=010", valid_out); end
    foreach (pkt[i]) begin
      read_port(1, d);
      nchecks++;
      if (d !== pkt[i]) begin nerr++; $display("FAIL basic_read%0d got=%h want=%h", i, d, pkt[i]); end
    end
    nchecks++;
    if (valid_out !== 3'b000) begin nerr++; $display("FAIL basic_empty got=%b want=000", valid_out); end
    read_port(1, d);
    nchecks++;
    if (d !== 8'h0D) begin nerr++; $display("FAIL empty_read_hold got=%h want=0d", d); end
  endtask

  task automatic test_parity_error();
    logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [7:0] d;
    foreach (pkt[i]) send_byte(pkt[i]);
    nchecks++;
    if (error !== 1'b1) begin nerr++; $display("FAIL parity_error_pulse got=%b want=1", error); end
    tick();
    nchecks++;
    if (error !== 1'b0) begin nerr++; $display("FAIL parity_error_width got=%b want=0", error); end
    foreach (pkt[i]) begin
      read_port(1, d);
      nchecks++;
      if (d !== pkt[i]) begin nerr++; $display("FAIL perr_read%0d got=%h want=%h", i, d, pkt[i]); end
    end
  endtask

  task automatic test_drop();
    logic [7:0] d;
    int drops = 0;
    send_byte(8'h03);
    nchecks++;
    if (drop !== 1'b1) begin nerr++; $display("FAIL drop_bad_dest got=%b want=1", drop); end
    send_byte(8'h55);
    nchecks++;
    if (drop !== 1'b0 || valid_out !== 3'b000) begin
      nerr++; $display("FAIL drop_bad_dest_after drop=%b valid=%b want 0/000", drop, valid_out);
    end
    send_byte(8'hFC);
    nchecks++;
    if (drop !== 1'b1) begin nerr++; $display("FAIL drop_oversize got=%b want=1", drop); end
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i + 1));
      if (drop) drops++;
    end
    nchecks++;
    if (drops !== 0 || valid_out !== 3'b000) begin
      nerr++; $display("FAIL drop_consume extra_drops=%0d valid=%b want 0/000", drops, valid_out);
    end
    send_byte(8'h02);
    send_byte(8'h02);
    nchecks++;
    if (valid_out !== 3'b100 || error !== 1'b0) begin
      nerr++; $display("FAIL drop_next_route valid=%b error=%b want 100/0", valid_out, error);
    end
    read_port(2, d);
    read_port(2, d);
    nchecks++;
    if (d !== 8'h02 || valid_out !== 3'b000) begin
      nerr++; $display("FAIL drop_next_read got=%h valid=%b want 02/000", d, valid_out);
    end
  endtask

  task automatic test_wait();
    logic [7:0] exp [16] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                             8'h0A, 8'h23, 8'h10, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h10};
    logic [7:0] d;
    int k = 0;
    send_byte(8'h28);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    send_byte(8'h23);
    nchecks++;
    if (valid_out !== 3'b001) begin nerr++; $display("FAIL wait_fill valid=%b want=001", valid_out); end
    send_byte(8'h10);
    nchecks++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL wait_busy got=%b want=1", busy); end
    // Source holds the first payload byte while the router is busy.
    pkt_valid = 1'b1;
    data_in   = 8'hA0;
    read_port(0, d);
    nchecks++;
    if (d !== 8'h28 || busy !== 1'b1) begin
      nerr++; $display("FAIL wait_read1 data=%h busy=%b want 28/1", d, busy);
    end
    read_port(0, d);
    nchecks++;
    if (d !== 8'h01 || busy !== 1'b1) begin
      nerr++; $display("FAIL wait_read2 data=%h busy=%b want 01/1", d, busy);
    end
    while (busy && k < 8) begin tick(); k++; end
    nchecks++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL wait_release busy=%b want=0 after %0d cycles", busy, k); end
    send_byte(8'hA0);
    send_byte(8'hB0);
    send_byte(8'hC0);
    send_byte(8'hD0);
    send_byte(8'h10);
    nchecks++;
    if (error !== 1'b0 || valid_out !== 3'b001) begin
      nerr++; $display("FAIL wait_store error=%b valid=%b want 0/001", error, valid_out);
    end
    foreach (exp[i]) begin
      read_port(0, d);
      nchecks++;
      if (d !== exp[i]) begin nerr++; $display("FAIL wait_drain%0d got=%h want=%h", i, d, exp[i]); end
    end
    nchecks++;
    if (valid_out !== 3'b000) begin nerr++; $display("FAIL wait_empty valid=%b want=000", valid_out); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    send_byte(8'h02);
    send_byte(8'h02);
    repeat (27) tick();
    read_port(2, d);
    nchecks++;
    if (d !== 8'h02 || valid_out !== 3'b100 || drop !== 1'b0) begin
      nerr++; $display("FAIL timeout_restart data=%h valid=%b drop=%b want 02/100/0", d, valid_out, drop);
    end
    repeat (29) tick();
    nchecks++;
    if (valid_out !== 3'b100 || drop !== 1'b0) begin
      nerr++; $display("FAIL timeout_early valid=%b drop=%b want 100/0", valid_out, drop);
    end
    tick();
    nchecks++;
    if (valid_out !== 3'b000 || drop !== 1'b1) begin
      nerr++; $display("FAIL timeout_flush valid=%b drop=%b want 000/1", valid_out, drop);
    end
    tick();
    nchecks++;
    if (drop !== 1'b0) begin nerr++; $display("FAIL timeout_drop_width got=%b want=0", drop); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic [7:0] d;
    send_byte(8'h0D);
    send_byte(8'h11);
    #2;
    reset_n = 1'b0;
    #1;
    nchecks++;
    if ({busy, error, drop} !== 3'b000 || valid_out !== 3'b000 || data_out !== '0) begin
      nerr++; $display("FAIL async_reset flags=%b valid=%b data=%h want all 0",
                       {busy, error, drop}, valid_out, data_out);
    end
    tick();
    reset_n = 1'b1;
    tick();
    foreach (pkt[i]) send_byte(pkt[i]);
    nchecks++;
    if (valid_out !== 3'b010 || error !== 1'b0) begin
      nerr++; $display("FAIL post_reset_store valid=%b error=%b want 010/0", valid_out, error);
    end
    foreach (pkt[i]) begin
      read_port(1, d);
      nchecks++;
      if (d !== pkt[i]) begin nerr++; $display("FAIL post_reset_read%0d got=%h want=%h", i, d, pkt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_drop();
    test_wait();
    test_timeout();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
